step_position_tracker: RTL and testbench
========================================

STEP_POSITION_TRACKER -- requirements
Module: step_position_tracker

Interface
REQ-001 Parameter NUM_STEPS, default 12'd400, steps per quarter turn (90 deg, 1/8 microstepping).
REQ-002 Parameter STEPS_PER_REV, default 11'd1600, position modulus.
REQ-003 Parameter MIN_PERIOD, default 16'd1000, minimum legal clk cycles between step rising edges.
REQ-004 Parameter IDLE_TIMEOUT, default 16'd10000, clk cycles without a step edge that end a move.
REQ-005 clk  in  1  system clock, 1 MHz; single clock domain.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 motor_step  in  1  asynchronous step pulse train; rising edge = one step.
REQ-008 motor_dir  in  1  asynchronous direction; 1 = forward (+1), 0 = reverse (-1).
REQ-009 clear  in  1  synchronous: zero position, clear faults, return to S_IDLE.
REQ-010 position  out  11  current position, 0..STEPS_PER_REV-1.
REQ-011 quadrant  out  2  position / NUM_STEPS (integer division).
REQ-012 aligned  out  1  high when position is a multiple of NUM_STEPS.
REQ-013 moving  out  1  high while state is S_MOVING.
REQ-014 move_done  out  1  one-cycle pulse at end of a move.
REQ-015 last_move_steps  out  12  step count of last completed move.
REQ-016 last_move_dir  out  1  direction of last completed move.
REQ-017 rate_fault  out  1  sticky; step interval below MIN_PERIOD seen.
REQ-018 dir_fault  out  1  sticky; direction changed within a move.

Function
REQ-019 motor_step and motor_dir SHALL each pass a 2-flop synchronizer; step edge = sync_step & ~prev_step using a third flop.
REQ-020 position SHALL update on the 3rd clk edge after motor_step rises (2 sync + 1 update); direction is the synchronized motor_dir at that edge.
REQ-021 Forward step SHALL wrap STEPS_PER_REV-1 -> 0; reverse step SHALL wrap 0 -> STEPS_PER_REV-1.
REQ-022 quadrant and aligned SHALL be registered alongside position (same cycle).
REQ-023 States: S_IDLE, S_MOVING, S_DONE.
REQ-024 S_IDLE: on step edge -> S_MOVING, move counter = 1, latch move dir, gap counter = 0.
REQ-025 S_MOVING: on step edge, move counter += 1 (saturate at 4095), gap counter = 0; if gap counter < MIN_PERIOD-1 set rate_fault; if dir differs from latched dir set dir_fault.
REQ-026 S_MOVING: with no edge, gap counter += 1 (saturate at 16'hFFFF); when gap counter == IDLE_TIMEOUT-1 -> S_DONE.
REQ-027 S_DONE: move_done = 1 for exactly this one cycle, load last_move_steps/last_move_dir, -> S_IDLE; a step edge arriving in S_DONE SHALL still update position and SHALL start a new move (-> S_MOVING, count 1).
REQ-028 clear SHALL take priority over a simultaneous step edge: the edge is dropped, position = 0, faults = 0, state = S_IDLE; last_move_* unchanged.
REQ-029 Faults SHALL remain set until clear or reset; they do not affect position tracking.

Reset
REQ-030 reset SHALL force: all sync flops 0, position 0, quadrant 0, aligned 1, moving 0, move_done 0, last_move_steps 0, last_move_dir 0, rate_fault 0, dir_fault 0, state S_IDLE, counters 0.
REQ-031 reset mid-move SHALL abandon the move with no move_done pulse.

Structure
REQ-032 State encodings (2 bits) and default NUM_STEPS/STEPS_PER_REV SHALL live in a shared plus-maze package/include also used by the stepper controller.
REQ-033 Synchronizer + edge detector SHALL be sub-module sync_edge_detect (one instance per input, edge output unused for dir).

Verification
REQ-034 400 forward steps at 2000-cycle period from reset -> position 400, quadrant 1, aligned 1, move_done once, last_move_steps 400, no faults.
REQ-035 From 0, 1 reverse step -> position 1599, quadrant 3, aligned 0.
REQ-036 Steps 500 cycles apart -> rate_fault = 1 on second edge, position still counts.
REQ-037 motor_dir toggled after 10 steps of a move -> dir_fault = 1; position returns per actual direction.
REQ-038 clear asserted in same cycle as detected step edge -> position 0, edge not counted, faults 0.
REQ-039 reset asserted mid-move (after 200 steps) -> all outputs to reset values, no move_done.

Source files
------------

// File: rtl/step_position_tracker_pkg.sv
// Shared plus-maze definitions: tracker state encoding, default geometry
// and position-to-quadrant helpers also used by the stepper controller.
package step_position_tracker_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVING = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [11:0] DEF_NUM_STEPS     = 12'd400;
  localparam logic [10:0] DEF_STEPS_PER_REV = 11'd1600;

  // Compare against multiples of n instead of dividing; valid while pos < 4*n.
  function automatic logic [1:0] quadrant_of(input logic [10:0] pos, input logic [11:0] n);
    logic [13:0] p;
    logic [13:0] n1;
    p  = {3'b000, pos};
    n1 = {2'b00, n};
    if (p >= n1 * 14'd3)      return 2'd3;
    else if (p >= n1 + n1)    return 2'd2;
    else if (p >= n1)         return 2'd1;
    else                      return 2'd0;
  endfunction

  function automatic logic on_boundary(input logic [10:0] pos, input logic [11:0] n);
    logic [13:0] p;
    logic [13:0] n1;
    p  = {3'b000, pos};
    n1 = {2'b00, n};
    return (p == 14'd0) || (p == n1) || (p == n1 + n1) || (p == n1 * 14'd3);
  endfunction

endpackage

// File: rtl/step_position_tracker_sync_edge.sv
// Two-flop synchronizer for an asynchronous level plus a third flop for
// rising-edge detection of the synchronized level.
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise
);

  logic meta_p0;
  logic sync_p1;
  logic prev_p2;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      prev_p2 <= sync_p1;
    end
  end

  assign level = sync_p1;
  assign rise  = sync_p1 & ~prev_p2;

endmodule

// File: rtl/step_position_tracker.sv
// Tracks stepper shaft position from an asynchronous step/dir pair, groups
// steps into moves separated by idle gaps and flags rate/direction faults.
module step_position_tracker
  import step_position_tracker_pkg::*;
#(
  parameter logic [11:0] NUM_STEPS     = DEF_NUM_STEPS,
  parameter logic [10:0] STEPS_PER_REV = DEF_STEPS_PER_REV,
  parameter logic [15:0] MIN_PERIOD    = 16'd1000,
  parameter logic [15:0] IDLE_TIMEOUT  = 16'd10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        motor_step,
  input  logic        motor_dir,
  input  logic        clear,
  output logic [10:0] position,
  output logic [1:0]  quadrant,
  output logic        aligned,
  output logic        moving,
  output logic        move_done,
  output logic [11:0] last_move_steps,
  output logic        last_move_dir,
  output logic        rate_fault,
  output logic        dir_fault
);

  logic        step_edge;
  logic        dir_sync;
  logic [10:0] pos_step;
  logic [11:0] move_cnt;
  logic        move_dir;
  logic [15:0] gap_cnt;
  state_t      state;
  state_t      state_next;

  sync_edge_detect u_step_sync (
    .clk   (clk),
    .reset (reset),
    .din   (motor_step),
    .level (),
    .rise  (step_edge)
  );

  sync_edge_detect u_dir_sync (
    .clk   (clk),
    .reset (reset),
    .din   (motor_dir),
    .level (dir_sync),
    .rise  ()
  );

  always_comb begin
    if (dir_sync)
      pos_step = (position == STEPS_PER_REV - 11'd1) ? 11'd0 : position + 11'd1;
    else
      pos_step = (position == 11'd0) ? STEPS_PER_REV - 11'd1 : position - 11'd1;
  end

  always_comb begin
    state_next = state;
    moving     = 1'b0;
    move_done  = 1'b0;
    case (state)
      S_IDLE: begin
        if (step_edge) state_next = S_MOVING;
      end
      S_MOVING: begin
        moving = 1'b1;
        if (!step_edge && gap_cnt == IDLE_TIMEOUT - 16'd1) state_next = S_DONE;
      end
      S_DONE: begin
        move_done  = 1'b1;
        state_next = step_edge ? S_MOVING : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    if (clear) state_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      position        <= 11'd0;
      quadrant        <= 2'd0;
      aligned         <= 1'b1;
      move_cnt        <= 12'd0;
      move_dir        <= 1'b0;
      gap_cnt         <= 16'd0;
      last_move_steps <= 12'd0;
      last_move_dir   <= 1'b0;
      rate_fault      <= 1'b0;
      dir_fault       <= 1'b0;
    end else begin
      state <= state_next;
      if (clear) begin
        // A coincident step edge is deliberately dropped here.
        position   <= 11'd0;
        quadrant   <= 2'd0;
        aligned    <= 1'b1;
        move_cnt   <= 12'd0;
        gap_cnt    <= 16'd0;
        rate_fault <= 1'b0;
        dir_fault  <= 1'b0;
      end else begin
        if (step_edge) begin
          position <= pos_step;
          quadrant <= quadrant_of(pos_step, NUM_STEPS);
          aligned  <= on_boundary(pos_step, NUM_STEPS);
        end
        case (state)
          S_MOVING: begin
            if (step_edge) begin
              if (move_cnt != 12'hFFF) move_cnt <= move_cnt + 12'd1;
              gap_cnt <= 16'd0;
              if (gap_cnt < MIN_PERIOD - 16'd1) rate_fault <= 1'b1;
              if (dir_sync != move_dir) dir_fault <= 1'b1;
            end else if (gap_cnt != 16'hFFFF) begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          S_DONE: begin
            last_move_steps <= move_cnt;
            last_move_dir   <= move_dir;
            if (step_edge) begin
              move_cnt <= 12'd1;
              move_dir <= dir_sync;
              gap_cnt  <= 16'd0;
            end
          end
          default: begin
            if (step_edge) begin
              move_cnt <= 12'd1;
              move_dir <= dir_sync;
              gap_cnt  <= 16'd0;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_position_tracker.sv
// Randomized and directed bench for step_position_tracker using a move-level
// reference model driven by the step intervals the bench itself generates.
module tb_step_position_tracker;

  localparam int NSI  = 20;
  localparam int SPRI = 80;
  localparam int MINI = 20;
  localparam int ITI  = 100;

  logic        clk;
  logic        reset;
  logic        motor_step;
  logic        motor_dir;
  logic        clear;
  logic [10:0] position;
  logic [1:0]  quadrant;
  logic        aligned;
  logic        moving;
  logic        move_done;
  logic [11:0] last_move_steps;
  logic        last_move_dir;
  logic        rate_fault;
  logic        dir_fault;

  step_position_tracker #(
    .NUM_STEPS     (12'd20),
    .STEPS_PER_REV (11'd80),
    .MIN_PERIOD    (16'd20),
    .IDLE_TIMEOUT  (16'd100)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .motor_step      (motor_step),
    .motor_dir       (motor_dir),
    .clear           (clear),
    .position        (position),
    .quadrant        (quadrant),
    .aligned         (aligned),
    .moving          (moving),
    .move_done       (move_done),
    .last_move_steps (last_move_steps),
    .last_move_dir   (last_move_dir),
    .rate_fault      (rate_fault),
    .dir_fault       (dir_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int done_seen = 0;

  always @(negedge clk) if (move_done === 1'b1) done_seen++;

  // Reference model: a move is a run of steps whose rising edges are at most
  // IDLE_TIMEOUT cycles apart; it completes once a longer gap follows.
  int m_pos, m_cnt, m_last_steps, m_done, since_last;
  bit m_rate, m_dirf, m_in_move, m_mdir, m_last_dir;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void model_complete();
    if (m_in_move) begin
      m_done++;
      m_last_steps = m_cnt;
      m_last_dir   = m_mdir;
      m_in_move    = 1'b0;
    end
  endfunction

  function automatic void model_step(input bit d, input int dt);
    if (m_in_move && dt <= ITI) begin
      if (m_cnt < 4095) m_cnt++;
      if (dt < MINI) m_rate = 1'b1;
      if (d != m_mdir) m_dirf = 1'b1;
    end else begin
      model_complete();
      m_in_move = 1'b1;
      m_cnt     = 1;
      m_mdir    = d;
    end
    m_pos = (m_pos + (d ? 1 : SPRI - 1)) % SPRI;
  endfunction

  function automatic void model_clear();
    m_pos = 0; m_rate = 0; m_dirf = 0; m_in_move = 0; m_cnt = 0;
  endfunction

  task automatic do_step(input bit d, input int period);
    model_step(d, since_last);
    motor_dir  = d;
    motor_step = 1'b1;
    repeat (2) @(negedge clk);
    motor_step = 1'b0;
    repeat (period - 2) @(negedge clk);
    since_last = period;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
    since_last += n;
  endtask

  task automatic settle();
    idle(ITI + 20);
    model_complete();
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    model_clear();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".position"}, 32'(position), 32'(m_pos));
    chk({tag, ".quadrant"}, 32'(quadrant), 32'(m_pos / NSI));
    chk({tag, ".aligned"}, 32'(aligned), 32'(m_pos % NSI == 0));
    chk({tag, ".rate_fault"}, 32'(rate_fault), 32'(m_rate));
    chk({tag, ".dir_fault"}, 32'(dir_fault), 32'(m_dirf));
    chk({tag, ".last_steps"}, 32'(last_move_steps), 32'(m_last_steps));
    chk({tag, ".last_dir"}, 32'(last_move_dir), 32'(m_last_dir));
    chk({tag, ".done_count"}, 32'(done_seen), 32'(m_done));
    chk({tag, ".moving"}, 32'(moving), 32'(m_in_move));
  endtask

  initial begin
    int nsteps;
    int per;
    bit d;
    reset = 1'b1; motor_step = 1'b0; motor_dir = 1'b0; clear = 1'b0;
    m_pos = 0; m_cnt = 0; m_last_steps = 0; m_done = 0; since_last = 1000000;
    m_rate = 0; m_dirf = 0; m_in_move = 0; m_mdir = 0; m_last_dir = 0;
    repeat (3) @(negedge clk);
    check_all("reset");
    chk("reset.move_done", 32'(move_done), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First step: position must change exactly on the third clock edge.
    model_step(1'b1, since_last);
    motor_dir = 1'b1; motor_step = 1'b1;
    @(negedge clk); chk("lat.edge1", 32'(position), 32'd0);
    @(negedge clk); chk("lat.edge2", 32'(position), 32'd0);
    @(negedge clk); chk("lat.edge3", 32'(position), 32'd1);
    chk("lat.moving", 32'(moving), 32'd1);
    motor_step = 1'b0;
    repeat (37) @(negedge clk);
    since_last = 40;
    for (int i = 1; i < NSI; i++) do_step(1'b1, 40);
    settle();
    check_all("quarter");

    do_clear();
    do_step(1'b0, 40);
    chk("rev.position", 32'(position), 32'd79);
    chk("rev.quadrant", 32'(quadrant), 32'd3);
    chk("rev.aligned", 32'(aligned), 32'd0);
    do_step(1'b1, 40);
    chk("wrap.position", 32'(position), 32'd0);
    settle();
    check_all("wrap");

    do_clear();
    do_step(1'b1, 10);
    chk("rate.first", 32'(rate_fault), 32'd0);
    do_step(1'b1, 40);
    chk("rate.second", 32'(rate_fault), 32'd1);
    settle();
    check_all("rate");

    do_clear();
    for (int i = 0; i < 10; i++) do_step(1'b1, 30);
    chk("dirf.before", 32'(dir_fault), 32'd0);
    for (int i = 0; i < 5; i++) do_step(1'b0, 30);
    settle();
    check_all("dirf");

    do_clear();
    do_step(1'b1, MINI);
    do_step(1'b1, MINI - 1);
    chk("bnd.min_ok", 32'(rate_fault), 32'd0);
    do_step(1'b1, ITI);
    chk("bnd.min_m1", 32'(rate_fault), 32'd1);
    do_step(1'b1, ITI + 1);
    do_step(1'b1, 40);
    settle();
    check_all("bnd");

    // Clear lands in the same cycle as a detected step edge.
    do_clear();
    motor_dir = 1'b1; motor_step = 1'b1;
    repeat (2) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0; motor_step = 1'b0;
    model_clear();
    since_last = 1000000;
    chk("clredge.position", 32'(position), 32'd0);
    chk("clredge.moving", 32'(moving), 32'd0);
    settle();
    check_all("clredge");

    for (int s = 0; s < 25; s++) begin
      nsteps = $urandom_range(1, 12);
      d = 1'($urandom_range(0, 1));
      for (int i = 0; i < nsteps; i++) begin
        if ($urandom_range(0, 7) == 0) d = ~d;
        case ($urandom_range(0, 5))
          0: per = MINI - 1;
          1: per = MINI;
          2: per = $urandom_range(MINI, ITI);
          3: per = ITI;
          4: per = ITI + 1;
          default: per = $urandom_range(3, MINI - 1);
        endcase
        do_step(d, per);
      end
      settle();
      check_all($sformatf("rnd%0d", s));
      if ($urandom_range(0, 1) == 1) do_clear();
    end

    // Reset in the middle of a move abandons it silently.
    do_clear();
    for (int i = 0; i < 30; i++) do_step(1'b1, 40);
    reset = 1'b1;
    @(negedge clk);
    m_pos = 0; m_rate = 0; m_dirf = 0; m_in_move = 0; m_cnt = 0;
    m_last_steps = 0; m_last_dir = 0;
    check_all("midreset");
    reset = 1'b0;
    since_last = 1000000;
    settle();
    check_all("midreset.after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
